// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port data/stack memory between the CPU control path and an
// external loader/debug requester. Every access runs IDLE -> ISSUE -> WAIT -> DONE.
module mem_port_arbiter #(
  parameter int MEM_LAT      = 1,
  parameter int CPU_PRIORITY = 0,
  parameter int AW           = 16,
  parameter int DW           = 16
) (
  input  logic          clk,
  input  logic          reset,
  // Handshake: a requester raises req with we/addr/wdata stable and keeps it high until
  // it sees done. done is a one-cycle acknowledge and is the only qualifier of rdata.
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_done,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic [DW-1:0] ext_rdata,
  output logic          ext_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT=%0d is outside 1..15", MEM_LAT);
  end

  logic [1:0]    state;
  logic [3:0]    lat_cnt;
  logic          last_grant;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          grant_ext;

  // A lone requester always wins; on a tie the CPU wins under fixed priority,
  // otherwise whichever side was not granted last.
  always_comb begin
    grant_ext = ext_req;
    if (cpu_req && ext_req) begin
      grant_ext = (CPU_PRIORITY != 0) ? 1'b0 : ~last_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cpu_rdata  <= '0;
      ext_rdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_req || ext_req) begin
            owner      <= grant_ext;
            last_grant <= grant_ext;
            lat_we     <= grant_ext ? ext_we    : cpu_we;
            lat_addr   <= grant_ext ? ext_addr  : cpu_addr;
            lat_wdata  <= grant_ext ? ext_wdata : cpu_wdata;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          lat_cnt <= LAT_LOAD;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_cnt == 4'd0) begin
            if (!lat_we) begin
              if (owner) begin
                ext_rdata <= mem_rdata;
              end else begin
                cpu_rdata <= mem_rdata;
              end
            end
            state <= ST_DONE;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory-side signals hold the latched access for its whole life and are zero in IDLE.
  assign busy      = (state != ST_IDLE);
  assign mem_en    = (state == ST_ISSUE);
  assign mem_we    = busy & lat_we;
  assign mem_addr  = busy ? lat_addr  : '0;
  assign mem_wdata = busy ? lat_wdata : '0;
  assign cpu_done  = (state == ST_DONE) & ~owner;
  assign ext_done  = (state == ST_DONE) &  owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 is MEM_LAT=1 round-robin, instance 1 is
// MEM_LAT=3 with fixed CPU priority; a timestamp-based access model predicts every output.
module tb_mem_port_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam int PRI0 = 0;
  localparam int PRI1 = 1;

  bit            clk = 1'b0;
  logic          reset;
  logic          cpu_req [2];
  logic          cpu_we [2];
  logic [AW-1:0] cpu_addr [2];
  logic [DW-1:0] cpu_wdata [2];
  logic [DW-1:0] cpu_rdata [2];
  logic          cpu_done [2];
  logic          ext_req [2];
  logic          ext_we [2];
  logic [AW-1:0] ext_addr [2];
  logic [DW-1:0] ext_wdata [2];
  logic [DW-1:0] ext_rdata [2];
  logic          ext_done [2];
  logic          mem_en [2];
  logic          mem_we [2];
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];
  logic          busy [2];
  logic          owner [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  mem_port_arbiter #(.MEM_LAT(LAT0), .CPU_PRIORITY(PRI0), .AW(AW), .DW(DW)) u_a (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_rdata(cpu_rdata[0]), .cpu_done(cpu_done[0]),
    .ext_req(ext_req[0]), .ext_we(ext_we[0]), .ext_addr(ext_addr[0]), .ext_wdata(ext_wdata[0]),
    .ext_rdata(ext_rdata[0]), .ext_done(ext_done[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]), .owner(owner[0])
  );

  mem_port_arbiter #(.MEM_LAT(LAT1), .CPU_PRIORITY(PRI1), .AW(AW), .DW(DW)) u_b (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_rdata(cpu_rdata[1]), .cpu_done(cpu_done[1]),
    .ext_req(ext_req[1]), .ext_we(ext_we[1]), .ext_addr(ext_addr[1]), .ext_wdata(ext_wdata[1]),
    .ext_rdata(ext_rdata[1]), .ext_done(ext_done[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]), .owner(owner[1])
  );

  // ---------------- clock ----------------
  initial begin
    forever #5 clk = ~clk;
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int pri_of(input int k);
    return (k == 0) ? PRI0 : PRI1;
  endfunction

  function automatic logic [DW-1:0] init_val(input int k, input int a);
    if (a == 'h10) return 16'hBEEF;
    return DW'(16'h3C00 + a * 3 + k * 256);
  endfunction

  // ---------------- memory environment ----------------
  // Read data is valid only in the cycle exactly MEM_LAT after mem_en; junk otherwise.
  logic [DW-1:0] store [2][256];
  bit            st_wr [2][256];
  int            rd_at [2];
  logic [DW-1:0] rd_val [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_en[k] === 1'b1) begin
        if (mem_we[k] === 1'b1) begin
          store[k][mem_addr[k][7:0]] = mem_wdata[k];
          st_wr[k][mem_addr[k][7:0]] = 1'b1;
        end else begin
          rd_at[k]  = cyc + lat_of(k);
          rd_val[k] = st_wr[k][mem_addr[k][7:0]] ? store[k][mem_addr[k][7:0]]
                                                 : init_val(k, int'(mem_addr[k][7:0]));
        end
      end
      mem_rdata[k] = (cyc == rd_at[k]) ? rd_val[k] : (16'h5A5A ^ DW'(cyc));
    end
  end

  // ---------------- reference model ----------------
  // An access granted at the edge ending cycle g occupies cycles g+1 .. g+2+LAT:
  // issue in the first, done in the last. Grants only happen outside that window.
  bit            m_act [2];
  int            m_iss [2];
  logic          m_win [2];
  logic          m_we [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata [2];
  logic          m_last [2];
  logic          m_owner [2];
  logic [DW-1:0] m_rd_cpu [2];
  logic [DW-1:0] m_rd_ext [2];
  logic [DW-1:0] ref_mem [2][256];
  bit            ref_wr [2][256];

  function automatic bit in_win(input int k, input int c);
    return m_act[k] && (c >= m_iss[k]) && (c <= m_iss[k] + lat_of(k) + 1);
  endfunction

  function automatic logic [DW-1:0] ref_read(input int k, input logic [AW-1:0] a);
    return ref_wr[k][a[7:0]] ? ref_mem[k][a[7:0]] : init_val(k, int'(a[7:0]));
  endfunction

  always @(posedge clk) begin
    int   ending;
    logic win;
    ending = cyc;
    cyc    = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_act[k]    = 1'b0;
        m_last[k]   = 1'b1;
        m_owner[k]  = 1'b0;
        m_rd_cpu[k] = '0;
        m_rd_ext[k] = '0;
      end else begin
        if (m_act[k] && !m_we[k] && ending == m_iss[k] + lat_of(k)) begin
          if (m_win[k]) m_rd_ext[k] = ref_read(k, m_addr[k]);
          else          m_rd_cpu[k] = ref_read(k, m_addr[k]);
        end
        if (!in_win(k, ending) && (cpu_req[k] || ext_req[k])) begin
          if (cpu_req[k] && ext_req[k]) win = (pri_of(k) != 0) ? 1'b0 : !m_last[k];
          else                          win = ext_req[k];
          m_act[k]   = 1'b1;
          m_iss[k]   = cyc;
          m_win[k]   = win;
          m_last[k]  = win;
          m_owner[k] = win;
          m_we[k]    = win ? ext_we[k]    : cpu_we[k];
          m_addr[k]  = win ? ext_addr[k]  : cpu_addr[k];
          m_wdata[k] = win ? ext_wdata[k] : cpu_wdata[k];
          if (m_we[k]) begin
            ref_mem[k][m_addr[k][7:0]] = m_wdata[k];
            ref_wr[k][m_addr[k][7:0]]  = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic cmp(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] cyc=%0d got=%0h expected=%0h", name, k, cyc, act, exp);
    end
  endtask

  task automatic check_cycle();
    for (int k = 0; k < 2; k++) begin
      int c;
      int l;
      bit w;
      c = cyc;
      l = lat_of(k);
      w = in_win(k, c);
      cmp("busy",      k, 32'(busy[k]),      32'(w));
      cmp("mem_en",    k, 32'(mem_en[k]),    32'(w && c == m_iss[k]));
      cmp("mem_we",    k, 32'(mem_we[k]),    32'(w && m_we[k]));
      cmp("mem_addr",  k, 32'(mem_addr[k]),  w ? 32'(m_addr[k]) : 32'd0);
      cmp("mem_wdata", k, 32'(mem_wdata[k]), w ? 32'(m_wdata[k]) : 32'd0);
      cmp("cpu_done",  k, 32'(cpu_done[k]),  32'(w && c == m_iss[k] + l + 1 && !m_win[k]));
      cmp("ext_done",  k, 32'(ext_done[k]),  32'(w && c == m_iss[k] + l + 1 && m_win[k]));
      cmp("owner",     k, 32'(owner[k]),     32'(m_owner[k]));
      cmp("cpu_rdata", k, 32'(cpu_rdata[k]), 32'(m_rd_cpu[k]));
      cmp("ext_rdata", k, 32'(ext_rdata[k]), 32'(m_rd_ext[k]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic cpu_set(input int k, input logic req, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    cpu_req[k] = req; cpu_we[k] = we; cpu_addr[k] = addr; cpu_wdata[k] = wdata;
  endtask

  task automatic ext_set(input int k, input logic req, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    ext_req[k] = req; ext_we[k] = we; ext_addr[k] = addr; ext_wdata[k] = wdata;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cpu_set(k, 1'b0, 1'b0, '0, '0);
      ext_set(k, 1'b0, 1'b0, '0, '0);
    end
    #1;
    goto(2);
    for (int k = 0; k < 2; k++) begin
      cmp("rst_busy",  k, 32'(busy[k]), 32'd0);
      cmp("rst_owner", k, 32'(owner[k]), 32'd0);
      cmp("rst_cpu_rdata", k, 32'(cpu_rdata[k]), 32'd0);
      cmp("rst_mem_en", k, 32'(mem_en[k]), 32'd0);
    end
    reset = 1'b0;

    // CPU read of 0x0010 (holds 0xBEEF), MEM_LAT=1.
    goto(5);
    cpu_set(0, 1'b1, 1'b0, 16'h0010, 16'h7777);
    goto(6);
    cmp("a_issue_en",   0, 32'(mem_en[0]), 32'd1);
    cmp("a_issue_addr", 0, 32'(mem_addr[0]), 32'h0010);
    cmp("a_busy6",      0, 32'(busy[0]), 32'd1);
    goto(7);
    cmp("a_busy7",      0, 32'(busy[0]), 32'd1);
    goto(8);
    cmp("a_done8",      0, 32'(cpu_done[0]), 32'd1);
    cmp("a_rdata8",     0, 32'(cpu_rdata[0]), 32'hBEEF);
    cmp("a_busy8",      0, 32'(busy[0]), 32'd1);
    cpu_set(0, 1'b0, 1'b0, '0, '0);
    goto(9);
    cmp("a_busy9",      0, 32'(busy[0]), 32'd0);

    // EXT write 0x1234 -> 0x00FF, MEM_LAT=3; req dropped mid-access.
    goto(10);
    ext_set(1, 1'b1, 1'b1, 16'h00FF, 16'h1234);
    goto(11);
    cmp("b_wr_en",    1, 32'(mem_en[1]), 32'd1);
    cmp("b_wr_we",    1, 32'(mem_we[1]), 32'd1);
    cmp("b_wr_addr",  1, 32'(mem_addr[1]), 32'h00FF);
    cmp("b_wr_wdata", 1, 32'(mem_wdata[1]), 32'h1234);
    goto(12);
    ext_set(1, 1'b0, 1'b0, '0, '0);
    goto(15);
    cmp("b_ext_done15", 1, 32'(ext_done[1]), 32'd1);
    cmp("b_ext_rdata_kept", 1, 32'(ext_rdata[1]), 32'd0);
    goto(16);
    cpu_set(1, 1'b1, 1'b0, 16'h00FF, 16'h0000);
    goto(21);
    cmp("b_readback_done", 1, 32'(cpu_done[1]), 32'd1);
    cmp("b_readback_data", 1, 32'(cpu_rdata[1]), 32'h1234);
    cpu_set(1, 1'b0, 1'b0, '0, '0);

    // Round-robin tie after reset: CPU first, then alternate every 4 cycles.
    goto(24);
    reset = 1'b1;
    goto(25);
    reset = 1'b0;
    cpu_set(0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    ext_set(0, 1'b1, 1'b1, 16'h0030, 16'hCAFE);
    goto(26);
    cmp("c_owner26", 0, 32'(owner[0]), 32'd0);
    goto(28);
    cmp("c_cpu_done28", 0, 32'(cpu_done[0]), 32'd1);
    cmp("c_cpu_rdata28", 0, 32'(cpu_rdata[0]), 32'h3C60);
    goto(30);
    cmp("c_owner30", 0, 32'(owner[0]), 32'd1);
    goto(32);
    cmp("c_ext_done32", 0, 32'(ext_done[0]), 32'd1);
    goto(36);
    cmp("c_cpu_done36", 0, 32'(cpu_done[0]), 32'd1);
    goto(40);
    cmp("c_ext_done40", 0, 32'(ext_done[0]), 32'd1);
    goto(41);
    cpu_set(0, 1'b0, 1'b0, '0, '0);
    ext_set(0, 1'b0, 1'b0, '0, '0);

    // Fixed priority tie: CPU twice back to back, EXT only after CPU drops.
    goto(45);
    cpu_set(1, 1'b1, 1'b0, 16'h00FF, 16'h0000);
    ext_set(1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    goto(46);
    cmp("d_en46", 1, 32'(mem_en[1]), 32'd1);
    goto(50);
    cmp("d_cpu_done50", 1, 32'(cpu_done[1]), 32'd1);
    cmp("d_ext_done50", 1, 32'(ext_done[1]), 32'd0);
    goto(51);
    cmp("d_idle51", 1, 32'(busy[1]), 32'd0);
    goto(52);
    cmp("d_en52", 1, 32'(mem_en[1]), 32'd1);
    cmp("d_owner52", 1, 32'(owner[1]), 32'd0);
    goto(56);
    cmp("d_cpu_done56", 1, 32'(cpu_done[1]), 32'd1);
    cpu_set(1, 1'b0, 1'b0, '0, '0);
    goto(58);
    cmp("d_owner58", 1, 32'(owner[1]), 32'd1);
    cmp("d_addr58", 1, 32'(mem_addr[1]), 32'h0010);
    goto(62);
    cmp("d_ext_done62", 1, 32'(ext_done[1]), 32'd1);
    cmp("d_ext_rdata62", 1, 32'(ext_rdata[1]), 32'hBEEF);
    ext_set(1, 1'b0, 1'b0, '0, '0);

    // Reset during WAIT of a CPU read aborts it; next tie goes to the CPU.
    goto(66);
    cpu_set(0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    goto(67);
    cmp("e_en67", 0, 32'(mem_en[0]), 32'd1);
    goto(68);
    cmp("e_busy68", 0, 32'(busy[0]), 32'd1);
    reset = 1'b1;
    cpu_set(0, 1'b0, 1'b0, '0, '0);
    goto(69);
    cmp("e_busy69", 0, 32'(busy[0]), 32'd0);
    cmp("e_done69", 0, 32'(cpu_done[0]), 32'd0);
    cmp("e_rdata69", 0, 32'(cpu_rdata[0]), 32'd0);
    reset = 1'b0;
    for (int c = 70; c <= 72; c++) begin
      goto(c);
      cmp("e_quiet_busy", 0, 32'(busy[0]), 32'd0);
      cmp("e_quiet_en",   0, 32'(mem_en[0]), 32'd0);
      cmp("e_quiet_done", 0, 32'(cpu_done[0]), 32'd0);
    end
    cpu_set(0, 1'b1, 1'b0, 16'h0050, 16'h0000);
    ext_set(0, 1'b1, 1'b0, 16'h0060, 16'h0000);
    goto(73);
    cmp("e_owner73", 0, 32'(owner[0]), 32'd0);
    cmp("e_addr73", 0, 32'(mem_addr[0]), 32'h0050);
    goto(75);
    cmp("e_cpu_done75", 0, 32'(cpu_done[0]), 32'd1);
    cmp("e_cpu_rdata75", 0, 32'(cpu_rdata[0]), 32'h3CF0);
    cpu_set(0, 1'b0, 1'b0, '0, '0);
    ext_set(0, 1'b0, 1'b0, '0, '0);
    goto(84);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
